// File: rtl/nano_mem_defs_pkg.sv
// Shared constants for the nano_riscv memory arbiter: default address width,
// full-word byte enable and read-owner encodings.
package nano_mem_defs;
  localparam int         ADDR_W_DEF = 10;
  localparam int         CNT_W      = 4;
  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic       OWN_IF     = 1'b0;
  localparam logic       OWN_LS     = 1'b1;
endpackage

// File: rtl/nano_starve_guard.sv
// Saturating count of consecutive cycles the fetch stage waited without a
// grant; raises force_win once the limit is reached so fetch cannot starve.
module nano_starve_guard
  import nano_mem_defs::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_waiting,
  input  logic i_granted,
  output logic o_force_win
);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear on a fetch grant or an idle fetch; otherwise count up and hold at LIMIT.
  always_comb begin
    cnt_d = '0;
    if (i_waiting && !i_granted)
      cnt_d = (cnt_q == LIMIT) ? cnt_q : cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge i_clk) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign o_force_win = (cnt_q == LIMIT);
endmodule

// File: rtl/nano_mem_arbiter.sv
// Shares one single-port 1-cycle-latency memory between fetch and load/store.
// Load/store wins by default; the starve guard hands a contended cycle to
// fetch after STARVE_MAX denials. Read data is steered back to its owner.
module nano_mem_arbiter
  import nano_mem_defs::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_gnt,
  output logic              o_if_rvalid,
  output logic [31:0]       o_if_rdata,
  input  logic              i_ls_req,
  input  logic              i_ls_we,
  input  logic [3:0]        i_ls_be,
  input  logic [ADDR_W-1:0] i_ls_addr,
  input  logic [31:0]       i_ls_wdata,
  output logic              o_ls_gnt,
  output logic              o_ls_rvalid,
  output logic [31:0]       o_ls_rdata,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [3:0]        o_mem_be,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  input  logic [31:0]       i_mem_rdata
);
  logic force_win;
  logic if_gnt, ls_gnt;
  logic rd_pend_q, rd_pend_d;
  logic rd_owner_q, rd_owner_d;

  nano_starve_guard #(.STARVE_MAX(STARVE_MAX)) u_guard (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_waiting   (i_if_req),
    .i_granted   (if_gnt),
    .o_force_win (force_win)
  );

  // Grant select and memory command mux; nothing is granted during reset.
  always_comb begin
    ls_gnt      = !i_rst && i_ls_req && !(i_if_req && force_win);
    if_gnt      = !i_rst && i_if_req && !ls_gnt;
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_be    = '0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (ls_gnt) begin
      o_mem_en    = 1'b1;
      o_mem_we    = i_ls_we;
      o_mem_be    = i_ls_we ? i_ls_be : BE_WORD;
      o_mem_addr  = i_ls_addr;
      o_mem_wdata = i_ls_we ? i_ls_wdata : 32'h0;
    end else if (if_gnt) begin
      o_mem_en    = 1'b1;
      o_mem_be    = BE_WORD;
      o_mem_addr  = i_if_addr;
    end
    rd_pend_d  = o_mem_en && !o_mem_we;
    rd_owner_d = ls_gnt ? OWN_LS : OWN_IF;
  end

  // Remember who issued this cycle's read so next cycle's data goes to them.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= OWN_IF;
    end else begin
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  assign o_if_gnt    = if_gnt;
  assign o_ls_gnt    = ls_gnt;
  // Reset also suppresses a response that was in flight when it arrived.
  assign o_if_rvalid = !i_rst && rd_pend_q && (rd_owner_q == OWN_IF);
  assign o_ls_rvalid = !i_rst && rd_pend_q && (rd_owner_q == OWN_LS);
  assign o_if_rdata  = o_if_rvalid ? i_mem_rdata : 32'h0;
  assign o_ls_rdata  = o_ls_rvalid ? i_mem_rdata : 32'h0;
endmodule

// File: tb/tb_nano_mem_arbiter.sv
// Directed bench for nano_mem_arbiter with a scoreboard: expected read
// responses (data + cycle) are queued when a read is granted and a monitor
// pops them when the DUT raises rvalid.
module tb_nano_mem_arbiter;
  localparam int ADDR_W = 10;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic              clk = 1'b0;
  logic              i_rst;
  logic              i_if_req;
  logic [ADDR_W-1:0] i_if_addr;
  logic              o_if_gnt, o_if_rvalid;
  logic [31:0]       o_if_rdata;
  logic              i_ls_req, i_ls_we;
  logic [3:0]        i_ls_be;
  logic [ADDR_W-1:0] i_ls_addr;
  logic [31:0]       i_ls_wdata;
  logic              o_ls_gnt, o_ls_rvalid;
  logic [31:0]       o_ls_rdata;
  logic              o_mem_en, o_mem_we;
  logic [3:0]        o_mem_be;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [31:0]       o_mem_wdata;
  logic [31:0]       i_mem_rdata;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t exp_if[$];
  exp_t exp_ls[$];

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  nano_mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(4)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_gnt(o_if_gnt),
    .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
    .i_ls_req(i_ls_req), .i_ls_we(i_ls_we), .i_ls_be(i_ls_be),
    .i_ls_addr(i_ls_addr), .i_ls_wdata(i_ls_wdata), .o_ls_gnt(o_ls_gnt),
    .o_ls_rvalid(o_ls_rvalid), .o_ls_rdata(o_ls_rdata),
    .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_be(o_mem_be),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural mem_file: byte-enabled write, registered 1-cycle read.
  always @(posedge clk) begin
    if (o_mem_en) begin
      if (o_mem_we) begin
        for (int b = 0; b < 4; b++)
          if (o_mem_be[b]) mem[o_mem_addr][b*8 +: 8] <= o_mem_wdata[b*8 +: 8];
      end else begin
        i_mem_rdata <= mem[o_mem_addr];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every rvalid must match the head of its owner's queue, in data and cycle.
  always @(negedge clk) begin
    exp_t e;
    if (o_if_rvalid) begin
      if (exp_if.size() == 0) chk("if_rvalid_unexpected", 32'd1, 32'd0);
      else begin
        e = exp_if.pop_front();
        chk("if_rdata", o_if_rdata, e.data);
        chk("if_rcycle", cyc, e.cyc);
      end
    end else chk("if_rdata_idle", o_if_rdata, 32'h0);
    if (o_ls_rvalid) begin
      if (exp_ls.size() == 0) chk("ls_rvalid_unexpected", 32'd1, 32'd0);
      else begin
        e = exp_ls.pop_front();
        chk("ls_rdata", o_ls_rdata, e.data);
        chk("ls_rcycle", cyc, e.cyc);
      end
    end else chk("ls_rdata_idle", o_ls_rdata, 32'h0);
  end

  task automatic drive(input logic rst, input logic ifr, input logic [ADDR_W-1:0] ifa,
                       input logic lsr, input logic we, input logic [3:0] be,
                       input logic [ADDR_W-1:0] lsa, input logic [31:0] wd);
    @(posedge clk); #1;
    i_rst = rst; i_if_req = ifr; i_if_addr = ifa;
    i_ls_req = lsr; i_ls_we = we; i_ls_be = be; i_ls_addr = lsa; i_ls_wdata = wd;
    #1;
  endtask

  task automatic exp_push(input logic is_ls, input logic [31:0] d);
    exp_t e;
    e.data = d; e.cyc = cyc + 1;
    if (is_ls) exp_ls.push_back(e); else exp_if.push_back(e);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 4'h0, '0, 32'h0);
    chk("idle_mem_en", {31'h0, o_mem_en}, 32'h0);
    chk("idle_mem_addr", {22'h0, o_mem_addr}, 32'h0);
  endtask

  initial begin
    i_rst = 1'b1; i_if_req = 0; i_if_addr = '0; i_ls_req = 0; i_ls_we = 0;
    i_ls_be = 0; i_ls_addr = '0; i_ls_wdata = 0; i_mem_rdata = 0;
    for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = 32'h0;
    mem[10'h010] = 32'h0000_0013;
    mem[10'h011] = 32'h0010_0093;
    mem[10'h020] = 32'h1122_3344;
    mem[10'h021] = 32'h5566_7788;
    mem[10'h030] = 32'hCAFE_0030;
    mem[10'h100] = 32'h1000_0100;
    mem[10'h200] = 32'h2000_0200;

    // Reset with both requesters active: nothing granted, memory port quiet.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 10'h010, 1'b1, 1'b0, 4'h0, 10'h030, 32'h0);
      chk("rst_if_gnt", {31'h0, o_if_gnt}, 32'h0);
      chk("rst_ls_gnt", {31'h0, o_ls_gnt}, 32'h0);
      chk("rst_mem_en", {31'h0, o_mem_en}, 32'h0);
      chk("rst_mem_addr", {22'h0, o_mem_addr}, 32'h0);
      chk("rst_rvalid", {30'h0, o_if_rvalid, o_ls_rvalid}, 32'h0);
    end
    // Release: load/store wins first.
    drive(1'b0, 1'b1, 10'h010, 1'b1, 1'b0, 4'h0, 10'h030, 32'h0);
    chk("rel_ls_gnt", {31'h0, o_ls_gnt}, 32'h1);
    chk("rel_if_gnt", {31'h0, o_if_gnt}, 32'h0);
    exp_push(1'b1, 32'hCAFE_0030);
    // Fetch read of 0x010 alone.
    drive(1'b0, 1'b1, 10'h010, 1'b0, 1'b0, 4'h0, '0, 32'h0);
    chk("fetch_gnt", {31'h0, o_if_gnt}, 32'h1);
    chk("fetch_mem_addr", {22'h0, o_mem_addr}, 32'h010);
    chk("fetch_mem_cmd", {26'h0, o_mem_en, o_mem_we, o_mem_be}, 32'h2F);
    exp_push(1'b0, 32'h0000_0013);
    idle();

    // Byte store then load of same address.
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 4'b0100, 10'h020, 32'h00AB_0000);
    chk("st_gnt", {31'h0, o_ls_gnt}, 32'h1);
    chk("st_mem_cmd", {26'h0, o_mem_en, o_mem_we, o_mem_be}, 32'h34);
    chk("st_mem_wdata", o_mem_wdata, 32'h00AB_0000);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 4'h0, 10'h020, 32'h0);
    chk("ld_gnt", {31'h0, o_ls_gnt}, 32'h1);
    chk("ld_mem_we", {31'h0, o_mem_we}, 32'h0);
    exp_push(1'b1, 32'h11AB_3344);
    idle();

    // Interleaved reads: fetch then load on consecutive cycles.
    drive(1'b0, 1'b1, 10'h011, 1'b0, 1'b0, 4'h0, '0, 32'h0);
    chk("il_if_gnt", {31'h0, o_if_gnt}, 32'h1);
    exp_push(1'b0, 32'h0010_0093);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 4'h0, 10'h021, 32'h0);
    chk("il_ls_gnt", {31'h0, o_ls_gnt}, 32'h1);
    exp_push(1'b1, 32'h5566_7788);
    idle();

    // Starvation: both held for 10 cycles -> LS,LS,LS,LS,IF repeating.
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 1'b1, 10'h100, 1'b1, 1'b0, 4'h0, 10'h200, 32'h0);
      if (k % 5 == 4) begin
        chk("starve_if_gnt", {30'h0, o_if_gnt, o_ls_gnt}, 32'h2);
        chk("starve_if_addr", {22'h0, o_mem_addr}, 32'h100);
        exp_push(1'b0, 32'h1000_0100);
      end else begin
        chk("starve_ls_gnt", {30'h0, o_if_gnt, o_ls_gnt}, 32'h1);
        chk("starve_ls_addr", {22'h0, o_mem_addr}, 32'h200);
        exp_push(1'b1, 32'h2000_0200);
      end
    end
    idle();
    idle();

    // Reset mid-read: load granted, reset next cycle -> no response ever.
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 4'h0, 10'h030, 32'h0);
    chk("mid_ld_gnt", {31'h0, o_ls_gnt}, 32'h1);
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 4'h0, '0, 32'h0);
    chk("mid_rst_ls_rvalid", {31'h0, o_ls_rvalid}, 32'h0);
    for (int k = 0; k < 4; k++) idle();

    chk("if_queue_drained", exp_if.size(), 32'd0);
    chk("ls_queue_drained", exp_ls.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net in case the stimulus ever stalls.
  initial begin
    #50000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
